// File: rtl/pipelined_cpu_core.sv
// 3-stage (IF/ID, EX+MEM, WB) core for the 4-bit-opcode ISA with RAW interlock, EX branch resolution,
// Z/N flags and retired-instruction counter. Define FWD_EN to replace the interlock with EX/WB forwarding.
module pipelined_cpu_core #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 6,
   parameter int PC_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_stall,
   output logic [PC_W-1:0]   out_imem_addr,
   input  logic [31:0]       in_imem_inst,
   output logic [DATA_W-1:0] out_dmem_addr,
   output logic [DATA_W-1:0] out_dmem_wdata,
   output logic              out_dmem_rd,
   output logic              out_dmem_wrt,
   input  logic [DATA_W-1:0] in_dmem_data,
   output logic              out_redirect,
   output logic [31:0]       out_instret
);

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ST   = 4'h3;
   localparam logic [3:0] OP_ADD  = 4'h4;
   localparam logic [3:0] OP_INC  = 4'h5;
   localparam logic [3:0] OP_NEG  = 4'h6;
   localparam logic [3:0] OP_SUB  = 4'h7;
   localparam logic [3:0] OP_J    = 4'h8;
   localparam logic [3:0] OP_BRZ  = 4'h9;
   localparam logic [3:0] OP_JM   = 4'hA;
   localparam logic [3:0] OP_BRN  = 4'hB;
   localparam logic [3:0] OP_LD   = 4'hE;
   localparam logic [3:0] OP_SVPC = 4'hF;
   localparam int         NREG    = 2 ** REG_AW;

   // Architectural state
   logic [PC_W-1:0]   r_pc;
   logic [DATA_W-1:0] r_rf [NREG];
   logic              r_z;
   logic              r_n;
   logic [31:0]       r_instret;

   // ID/EX pipeline register
   logic              r_idex_valid;
   logic [3:0]        r_idex_op;
   logic [PC_W-1:0]   r_idex_pc;
   logic [REG_AW-1:0] r_idex_rd;
   logic [REG_AW-1:0] r_idex_sa;
   logic [REG_AW-1:0] r_idex_sb;
   logic              r_idex_use_a;
   logic              r_idex_use_b;
   logic              r_idex_wr;
   logic [DATA_W-1:0] r_idex_a;
   logic [DATA_W-1:0] r_idex_b;
   logic [DATA_W-1:0] r_idex_imm;

   // EX/WB pipeline register
   logic              r_exwb_valid;
   logic              r_exwb_wr;
   logic              r_exwb_cnt;
   logic [REG_AW-1:0] r_exwb_rd;
   logic [DATA_W-1:0] r_exwb_data;

   // Decode signals
   logic [3:0]        w_op;
   logic [REG_AW-1:0] w_rd;
   logic [REG_AW-1:0] w_rs;
   logic [REG_AW-1:0] w_rt;
   logic [REG_AW-1:0] w_sb;
   logic              w_use_a;
   logic              w_use_b;
   logic              w_wr;
   logic [DATA_W-1:0] w_imm;
   logic [DATA_W-1:0] w_rf_a;
   logic [DATA_W-1:0] w_rf_b;
   logic              w_wb_we;
   logic              w_hazard;

   // EX signals
   logic [DATA_W-1:0] w_ex_a;
   logic [DATA_W-1:0] w_ex_b;
   logic [DATA_W-1:0] w_ex_res;
   logic              w_ex_flag_upd;
   logic              w_taken;
   logic [PC_W-1:0]   w_target;

   assign w_rd = in_imem_inst[22 +: REG_AW];
   assign w_rs = in_imem_inst[16 +: REG_AW];
   assign w_rt = in_imem_inst[10 +: REG_AW];

   // Unlisted opcodes collapse to NOP here so the rest of the pipe sees only legal ops.
   always_comb begin
      w_op    = OP_NOP;
      w_use_a = 1'b0;
      w_use_b = 1'b0;
      w_wr    = 1'b0;
      case (in_imem_inst[31:28])
         OP_SVPC: begin w_op = OP_SVPC; w_wr = 1'b1; end
         OP_LD:   begin w_op = OP_LD;   w_use_a = 1'b1; w_wr = 1'b1; end
         OP_ST:   begin w_op = OP_ST;   w_use_a = 1'b1; w_use_b = 1'b1; end
         OP_ADD:  begin w_op = OP_ADD;  w_use_a = 1'b1; w_use_b = 1'b1; w_wr = 1'b1; end
         OP_INC:  begin w_op = OP_INC;  w_use_a = 1'b1; w_wr = 1'b1; end
         OP_NEG:  begin w_op = OP_NEG;  w_use_a = 1'b1; w_wr = 1'b1; end
         OP_SUB:  begin w_op = OP_SUB;  w_use_a = 1'b1; w_use_b = 1'b1; w_wr = 1'b1; end
         OP_J:    begin w_op = OP_J;    w_use_a = 1'b1; end
         OP_BRZ:  begin w_op = OP_BRZ;  w_use_a = 1'b1; end
         OP_JM:   begin w_op = OP_JM;   w_use_a = 1'b1; end
         OP_BRN:  begin w_op = OP_BRN;  w_use_a = 1'b1; end
         default: w_op = OP_NOP;
      endcase
   end

   assign w_sb  = (w_op == OP_ST) ? w_rd : w_rt;
   assign w_imm = (w_op == OP_SVPC) ? DATA_W'($signed(in_imem_inst[21:0]))
                                    : DATA_W'($signed(in_imem_inst[15:0]));

   // Write-first register file: a WB write to the index being read is visible in the same cycle.
   assign w_wb_we = r_exwb_valid & r_exwb_wr;
   assign w_rf_a  = (w_wb_we && r_exwb_rd == w_rs) ? r_exwb_data : r_rf[w_rs];
   assign w_rf_b  = (w_wb_we && r_exwb_rd == w_sb) ? r_exwb_data : r_rf[w_sb];

`ifdef FWD_EN
   assign w_hazard = 1'b0;
   assign w_ex_a = (w_wb_we && r_idex_use_a && r_exwb_rd == r_idex_sa) ? r_exwb_data : r_idex_a;
   assign w_ex_b = (w_wb_we && r_idex_use_b && r_exwb_rd == r_idex_sb) ? r_exwb_data : r_idex_b;
`else
   // One bubble whenever ID needs a register the EX instruction is about to produce.
   assign w_hazard = r_idex_valid & r_idex_wr &
                     ((w_use_a & (w_rs == r_idex_rd)) | (w_use_b & (w_sb == r_idex_rd)));
   assign w_ex_a = r_idex_a;
   assign w_ex_b = r_idex_b;
`endif

   always_comb begin
      w_ex_res      = '0;
      w_ex_flag_upd = 1'b0;
      w_taken       = 1'b0;
      case (r_idex_op)
         OP_SVPC: w_ex_res = DATA_W'(r_idex_pc) + r_idex_imm;
         OP_LD:   w_ex_res = in_dmem_data;
         OP_ADD:  begin w_ex_res = w_ex_a + w_ex_b;     w_ex_flag_upd = 1'b1; end
         OP_INC:  begin w_ex_res = w_ex_a + r_idex_imm; w_ex_flag_upd = 1'b1; end
         OP_NEG:  begin w_ex_res = '0 - w_ex_a;         w_ex_flag_upd = 1'b1; end
         OP_SUB:  begin w_ex_res = w_ex_a - w_ex_b;     w_ex_flag_upd = 1'b1; end
         OP_J:    w_taken = 1'b1;
         OP_BRZ:  w_taken = r_z;
         OP_JM:   w_taken = 1'b1;
         OP_BRN:  w_taken = r_n;
         default: w_ex_res = '0;
      endcase
      w_ex_flag_upd = w_ex_flag_upd & r_idex_valid;
      w_taken       = w_taken & r_idex_valid;
   end

   assign w_target = (r_idex_op == OP_JM) ? in_dmem_data[PC_W-1:0] : w_ex_a[PC_W-1:0];

   // ST M[rd]=rs: port B carries the address register, port A the data.
   assign out_dmem_addr  = (r_idex_op == OP_ST) ? w_ex_b : w_ex_a;
   assign out_dmem_wdata = w_ex_a;
   assign out_dmem_rd    = r_idex_valid & ((r_idex_op == OP_LD) | (r_idex_op == OP_JM));
   assign out_dmem_wrt   = r_idex_valid & (r_idex_op == OP_ST) & ~in_stall;
   assign out_redirect   = w_taken & ~in_stall;
   assign out_imem_addr  = r_pc;
   assign out_instret    = r_instret;

   // Fetch/decode stage: redirect beats interlock; a stall freezes everything including a pending redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc         <= '0;
         r_idex_valid <= 1'b0;
         r_idex_op    <= OP_NOP;
         r_idex_pc    <= '0;
         r_idex_rd    <= '0;
         r_idex_sa    <= '0;
         r_idex_sb    <= '0;
         r_idex_use_a <= 1'b0;
         r_idex_use_b <= 1'b0;
         r_idex_wr    <= 1'b0;
         r_idex_a     <= '0;
         r_idex_b     <= '0;
         r_idex_imm   <= '0;
      end else if (!in_stall) begin
         if (w_taken) begin
            r_pc         <= w_target;
            r_idex_valid <= 1'b0;
         end else if (w_hazard) begin
            r_idex_valid <= 1'b0;
         end else begin
            r_pc         <= r_pc + PC_W'(1);
            r_idex_valid <= 1'b1;
         end
         r_idex_op    <= w_op;
         r_idex_pc    <= r_pc;
         r_idex_rd    <= w_rd;
         r_idex_sa    <= w_rs;
         r_idex_sb    <= w_sb;
         r_idex_use_a <= w_use_a;
         r_idex_use_b <= w_use_b;
         r_idex_wr    <= w_wr;
         r_idex_a     <= w_rf_a;
         r_idex_b     <= w_rf_b;
         r_idex_imm   <= w_imm;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exwb_valid <= 1'b0;
         r_exwb_wr    <= 1'b0;
         r_exwb_cnt   <= 1'b0;
         r_exwb_rd    <= '0;
         r_exwb_data  <= '0;
         r_z          <= 1'b0;
         r_n          <= 1'b0;
      end else if (!in_stall) begin
         r_exwb_valid <= r_idex_valid;
         r_exwb_wr    <= r_idex_wr;
         r_exwb_cnt   <= (r_idex_op != OP_NOP);
         r_exwb_rd    <= r_idex_rd;
         r_exwb_data  <= w_ex_res;
         if (w_ex_flag_upd) begin
            r_z <= (w_ex_res == '0);
            r_n <= w_ex_res[DATA_W-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
         r_instret <= '0;
      end else if (!in_stall) begin
         if (w_wb_we) r_rf[r_exwb_rd] <= r_exwb_data;
         if (r_exwb_valid && r_exwb_cnt) r_instret <= r_instret + 32'd1;
      end
   end

endmodule

// File: tb/tb_pipelined_cpu_core.sv
// Directed bench for pipelined_cpu_core: small programs in a behavioural imem/dmem, checks on
// store traffic, fetch addresses, redirect pulses and the retired count. Works with or without FWD_EN.
module tb_pipelined_cpu_core;

  localparam logic [3:0] OP_NOP = 4'h0, OP_ST = 4'h3, OP_ADD = 4'h4, OP_INC = 4'h5,
                         OP_NEG = 4'h6, OP_SUB = 4'h7, OP_BRZ = 4'h9, OP_JM = 4'hA,
                         OP_BRN = 4'hB, OP_LD = 4'hE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_stall = 1'b0;
  logic [31:0] out_imem_addr;
  logic [31:0] in_imem_inst;
  logic [31:0] out_dmem_addr;
  logic [31:0] out_dmem_wdata;
  logic        out_dmem_rd;
  logic        out_dmem_wrt;
  logic [31:0] in_dmem_data;
  logic        out_redirect;
  logic [31:0] out_instret;

  logic [31:0] imem [256];
  logic [31:0] dinit [256];
  logic [31:0] dmem [256];
  logic [63:0] wr_log [$];
  int          wr_cyc [$];
  logic [63:0] exp_q [$];
  int          cyc;
  int          redir_cnt;
  int          rd_cnt;
  int          total = 0;
  int          bad = 0;

  pipelined_cpu_core dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_stall      (in_stall),
    .out_imem_addr (out_imem_addr),
    .in_imem_inst  (in_imem_inst),
    .out_dmem_addr (out_dmem_addr),
    .out_dmem_wdata(out_dmem_wdata),
    .out_dmem_rd   (out_dmem_rd),
    .out_dmem_wrt  (out_dmem_wrt),
    .in_dmem_data  (in_dmem_data),
    .out_redirect  (out_redirect),
    .out_instret   (out_instret)
  );

  // clock / reset-aware memory models and monitors
  always #5 clk = ~clk;

  always_comb begin
    in_imem_inst = 32'h0;
    if (out_imem_addr < 32'd256) in_imem_inst = imem[out_imem_addr[7:0]];
  end

  always_comb begin
    in_dmem_data = 32'h0;
    if (out_dmem_addr < 32'd256) in_dmem_data = dmem[out_dmem_addr[7:0]];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem <= dinit;
      wr_log.delete();
      wr_cyc.delete();
      cyc <= 0;
    end else begin
      cyc <= cyc + 1;
      if (out_dmem_wrt) begin
        wr_log.push_back({out_dmem_addr, out_dmem_wdata});
        wr_cyc.push_back(cyc);
        if (out_dmem_addr < 32'd256) dmem[out_dmem_addr[7:0]] <= out_dmem_wdata;
      end
    end
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_cnt <= 0;
      rd_cnt <= 0;
    end else begin
      if (out_redirect) redir_cnt <= redir_cnt + 1;
      if (out_dmem_rd) rd_cnt <= rd_cnt + 1;
    end
  end

  // driver tasks
  function automatic logic [31:0] f_r(input logic [3:0] op, input int rd, input int rs, input int rt);
    logic [5:0] d, s, t;
    d = rd[5:0]; s = rs[5:0]; t = rt[5:0];
    return {op, d, s, t, 10'd0};
  endfunction

  function automatic logic [31:0] f_i(input logic [3:0] op, input int rd, input int rs, input int imm);
    logic [5:0] d, s;
    logic [15:0] m;
    d = rd[5:0]; s = rs[5:0]; m = imm[15:0];
    return {op, d, s, m};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 32'h0;
      dinit[i] = 32'h0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_stall = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_stall_prog();
    clear_mem();
    imem[0] = f_i(OP_INC, 5, 0, 16'h10);
    imem[1] = f_i(OP_INC, 6, 0, 16'h22);
    imem[2] = 32'h0;
    imem[3] = f_r(OP_ST, 5, 6, 0);
    imem[4] = f_i(OP_INC, 7, 0, 1);
    imem[5] = f_r(OP_ST, 0, 7, 0);
  endtask

  // scoreboard: compare the logged store stream against exp_q
  task automatic check_log(input string name);
    logic [63:0] got;
    total++;
    if (wr_log.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s_nwrites got=%0d exp=%0d", name, wr_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < wr_log.size()) ? wr_log[i] : 64'hx;
      total++;
      if (got !== exp_q[i]) begin
        bad++;
        $display("FAIL %s_write%0d got=%h exp=%h", name, i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    clear_mem();
    rst_n = 1'b0;
    #2;
    total++;
    if (out_imem_addr !== 32'h0 || out_instret !== 32'h0) begin
      bad++;
      $display("FAIL reset_state pc=%h instret=%0d exp 0/0", out_imem_addr, out_instret);
    end
    total++;
    if (out_dmem_wrt !== 1'b0 || out_dmem_rd !== 1'b0 || out_redirect !== 1'b0) begin
      bad++;
      $display("FAIL reset_strobes wrt=%b rd=%b redir=%b exp 000", out_dmem_wrt, out_dmem_rd, out_redirect);
    end
    do_reset();
    run(3);
    total++;
    if (out_imem_addr !== 32'd3) begin
      bad++;
      $display("FAIL nop_pc got=%h exp=3", out_imem_addr);
    end
    total++;
    if (out_instret !== 32'd0) begin
      bad++;
      $display("FAIL nop_instret got=%0d exp=0", out_instret);
    end
  endtask

  task automatic test_raw();
    int exp_pc3, exp_wcyc;
`ifdef FWD_EN
    exp_pc3 = 3; exp_wcyc = 4;
`else
    exp_pc3 = 2; exp_wcyc = 6;
`endif
    clear_mem();
    imem[0] = f_i(OP_INC, 1, 0, 5);
    imem[1] = f_i(OP_INC, 2, 0, 7);
    imem[2] = f_r(OP_ADD, 3, 1, 2);
    imem[3] = f_r(OP_ST, 0, 3, 0);
    do_reset();
    run(3);
    total++;
    if (out_imem_addr !== 32'(exp_pc3)) begin
      bad++;
      $display("FAIL raw_pc_c3 got=%0d exp=%0d", out_imem_addr, exp_pc3);
    end
    run(12);
    exp_q = '{{32'h0, 32'd12}};
    check_log("raw");
    total++;
    if (wr_cyc.size() != 1 || wr_cyc[0] != exp_wcyc) begin
      bad++;
      $display("FAIL raw_store_cycle got=%0d exp=%0d", (wr_cyc.size() > 0) ? wr_cyc[0] : -1, exp_wcyc);
    end
    total++;
    if (out_instret !== 32'd4) begin
      bad++;
      $display("FAIL raw_instret got=%0d exp=4", out_instret);
    end
  endtask

  task automatic test_branch();
    clear_mem();
    imem[0]     = f_i(OP_INC, 4, 0, 16'h20);
    imem[1]     = f_i(OP_INC, 1, 0, 16'hFFFF);
    imem[2]     = f_r(OP_BRN, 0, 4, 0);
    imem[3]     = f_i(OP_INC, 9, 0, 1);
    imem[8'h20] = f_r(OP_ST, 0, 1, 0);
    imem[8'h21] = f_r(OP_ST, 4, 9, 0);
    do_reset();
    run(3);
    total++;
    if (out_redirect !== 1'b1 || out_imem_addr !== 32'd3) begin
      bad++;
      $display("FAIL brn_pulse redir=%b pc=%h exp 1/3", out_redirect, out_imem_addr);
    end
    run(1);
    total++;
    if (out_redirect !== 1'b0 || out_imem_addr !== 32'h20) begin
      bad++;
      $display("FAIL brn_target redir=%b pc=%h exp 0/20", out_redirect, out_imem_addr);
    end
    run(8);
    exp_q = '{{32'h0, 32'hFFFF_FFFF}, {32'h20, 32'h0}};
    check_log("brn");
    total++;
    if (out_instret !== 32'd5 || redir_cnt != 1) begin
      bad++;
      $display("FAIL brn_counts instret=%0d redirs=%0d exp 5/1", out_instret, redir_cnt);
    end
  endtask

  task automatic test_ld_st();
    clear_mem();
    dinit[8'h40] = 32'h50;
    imem[0]     = f_i(OP_INC, 5, 0, 16'h10);
    imem[1]     = f_i(OP_INC, 6, 0, 16'hAB);
    imem[2]     = f_r(OP_ST, 5, 6, 0);
    imem[3]     = f_r(OP_LD, 7, 5, 0);
    imem[4]     = f_r(OP_ADD, 8, 7, 7);
    imem[5]     = f_r(OP_ST, 0, 8, 0);
    imem[6]     = f_i(OP_INC, 10, 0, 16'h30);
    imem[7]     = f_r(OP_ST, 10, 7, 0);
    imem[8]     = f_i(OP_INC, 11, 0, 16'h40);
    imem[9]     = f_r(OP_JM, 0, 11, 0);
    imem[10]    = f_r(OP_ST, 0, 11, 0);
    imem[8'h50] = f_r(OP_ST, 11, 5, 0);
    do_reset();
    run(30);
    exp_q = '{{32'h10, 32'hAB}, {32'h0, 32'h156}, {32'h30, 32'hAB}, {32'h40, 32'h10}};
    check_log("ldst");
    total++;
    if (dmem[8'h10] !== 32'hAB) begin
      bad++;
      $display("FAIL ldst_mem10 got=%h exp=ab", dmem[8'h10]);
    end
    total++;
    if (out_instret !== 32'd11 || rd_cnt != 2) begin
      bad++;
      $display("FAIL ldst_counts instret=%0d rd_cycles=%0d exp 11/2", out_instret, rd_cnt);
    end
  endtask

  task automatic test_flags();
    clear_mem();
    dinit[8'h50] = 32'h8000_0000;
    dinit[8'h70] = 32'hDEAD;
    imem[0]     = f_i(OP_INC, 1, 0, 3);
    imem[1]     = f_i(OP_INC, 9, 0, 16'h40);
    imem[2]     = f_r(OP_SUB, 1, 1, 1);
    imem[3]     = f_r(OP_BRZ, 0, 9, 0);
    imem[4]     = f_i(OP_INC, 2, 0, 1);
    imem[8'h40] = f_i(OP_INC, 13, 0, 16'h50);
    imem[8'h41] = f_i(OP_INC, 15, 0, 16'h60);
    imem[8'h42] = f_r(OP_LD, 12, 13, 0);
    imem[8'h43] = f_r(OP_NEG, 14, 12, 0);
    imem[8'h44] = f_r(OP_BRZ, 0, 13, 0);
    imem[8'h45] = f_r(OP_BRN, 0, 15, 0);
    imem[8'h46] = f_i(OP_INC, 2, 0, 1);
    imem[8'h47] = f_r(OP_ST, 0, 2, 0);
    imem[8'h60] = f_r(OP_ST, 15, 14, 0);
    imem[8'h61] = f_i(OP_INC, 16, 0, 16'h70);
    imem[8'h62] = f_r(OP_ST, 16, 1, 0);
    imem[8'h63] = f_r(OP_ST, 0, 2, 0);
    do_reset();
    run(35);
    exp_q = '{{32'h60, 32'h8000_0000}, {32'h70, 32'h0}, {32'h0, 32'h0}};
    check_log("flags");
    total++;
    if (out_instret !== 32'd14 || redir_cnt != 2) begin
      bad++;
      $display("FAIL flags_counts instret=%0d redirs=%0d exp 14/2", out_instret, redir_cnt);
    end
  endtask

  task automatic test_stall();
    load_stall_prog();
    do_reset();
    run(4);
    total++;
    if (out_dmem_wrt !== 1'b1 || out_dmem_addr !== 32'h10 || out_dmem_wdata !== 32'h22) begin
      bad++;
      $display("FAIL stall_st_ex wrt=%b addr=%h data=%h exp 1/10/22", out_dmem_wrt, out_dmem_addr, out_dmem_wdata);
    end
    in_stall = 1'b1;
    #1;
    total++;
    if (out_dmem_wrt !== 1'b0) begin
      bad++;
      $display("FAIL stall_wrt_gate got=%b exp=0", out_dmem_wrt);
    end
    for (int k = 0; k < 3; k++) begin
      run(1);
      total++;
      if (out_imem_addr !== 32'd4 || out_instret !== 32'd2 || wr_log.size() != 0) begin
        bad++;
        $display("FAIL stall_frozen%0d pc=%h instret=%0d writes=%0d exp 4/2/0", k, out_imem_addr, out_instret, wr_log.size());
      end
    end
    in_stall = 1'b0;
    run(10);
    exp_q = '{{32'h10, 32'h22}, {32'h0, 32'h1}};
    check_log("stall");
    total++;
    if (out_instret !== 32'd5) begin
      bad++;
      $display("FAIL stall_instret got=%0d exp=5", out_instret);
    end
  endtask

  task automatic test_async_reset();
    load_stall_prog();
    do_reset();
    run(4);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_imem_addr !== 32'h0 || out_dmem_wrt !== 1'b0 || out_instret !== 32'h0) begin
      bad++;
      $display("FAIL async_reset pc=%h wrt=%b instret=%0d exp 0/0/0", out_imem_addr, out_dmem_wrt, out_instret);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(14);
    exp_q = '{{32'h10, 32'h22}, {32'h0, 32'h1}};
    check_log("rerun");
    total++;
    if (out_instret !== 32'd5) begin
      bad++;
      $display("FAIL rerun_instret got=%0d exp=5", out_instret);
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_branch();
    test_ld_st();
    test_flags();
    test_stall();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
